redun_to_canon_serializer: RTL and testbench

Consumes one redundant-form product vector: DSP_BIT_LEN-bit coefficients, each worth 2^(WORD_LEN*i), as produced by the multi-mode multiplier array.
Resolves inter-word carries serially and streams canonical WORD_LEN-bit words, least-significant first, over a valid/ready interface.
Sits between the multiplier output register and any consumer that needs a fully normalised integer, such as the host readback path or the final-result comparator.

---
 rtl/redun_to_canon_serializer.sv | 168 ++++++++++++++++
 tb/tb_redun_to_canon_serializer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/redun_to_canon_serializer.sv
// Serializes one redundant-form product vector into canonical words, least significant first.
// Carries between words are resolved one word per accepted beat.
module redun_to_canon_serializer #(
    parameter int unsigned NUM_ELEMENTS = 66,
    parameter int unsigned DSP_BIT_LEN  = 17,
    parameter int unsigned WORD_LEN     = 16,
    parameter int unsigned IDX_W        = $clog2(NUM_ELEMENTS)
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                i_val,
    output logic                                o_rdy,
    input  logic [NUM_ELEMENTS*DSP_BIT_LEN-1:0] i_dat,
    output logic                                o_val,
    input  logic                                i_rdy,
    output logic [WORD_LEN-1:0]                 o_dat,
    output logic [IDX_W-1:0]                    o_idx,
    output logic                                o_last,
    output logic [1:0]                          o_carry
);

    localparam int unsigned SUM_W    = DSP_BIT_LEN + 1;
    localparam int unsigned LAST_IDX = NUM_ELEMENTS - 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DSP_BIT_LEN-1:0]  r_coef [NUM_ELEMENTS];
    logic [DSP_BIT_LEN-1:0]  w_shift [NUM_ELEMENTS];
    logic [1:0]              r_carry;
    logic [1:0]              w_carry_nxt;
    logic [IDX_W-1:0]        r_idx;
    logic [IDX_W-1:0]        w_idx_nxt;
    logic [IDX_W-1:0]        w_idx_inc;
    logic [WORD_LEN-1:0]     r_dat;
    logic [WORD_LEN-1:0]     w_dat_nxt;
    logic                    r_last;
    logic                    w_last_nxt;
    logic [1:0]              r_cout;
    logic [1:0]              w_cout_nxt;
    logic                    r_val;
    logic                    w_val_nxt;
    logic                    r_rdy;
    logic                    w_rdy_nxt;
    logic                    w_load;
    logic                    w_adv;
    logic [DSP_BIT_LEN-1:0]  w_in0;
    logic [SUM_W-1:0]        w_sum_cur;
    logic [SUM_W-1:0]        w_sum_nxt;
    logic [1:0]              w_carry_adv;

    // Coefficients shift down one slot per accepted word, so the current word is always slot 0.
    for (genvar g = 0; g < NUM_ELEMENTS; g++) begin : g_shift
        if (g < LAST_IDX) begin : g_mid
            assign w_shift[g] = r_coef[g+1];
        end else begin : g_top
            assign w_shift[g] = '0;
        end
    end

    assign w_in0       = i_dat[DSP_BIT_LEN-1:0];
    assign w_sum_cur   = SUM_W'(r_coef[0]) + SUM_W'(r_carry);
    assign w_carry_adv = 2'(w_sum_cur >> WORD_LEN);
    // Output registers are preloaded with the next word's sum so outputs never see i_rdy.
    assign w_sum_nxt   = SUM_W'(w_shift[0]) + SUM_W'(w_carry_adv);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_carry <= '0;
            r_idx   <= '0;
            r_dat   <= '0;
            r_last  <= 1'b0;
            r_cout  <= '0;
            r_val   <= 1'b0;
            r_rdy   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_carry <= w_carry_nxt;
            r_idx   <= w_idx_nxt;
            r_dat   <= w_dat_nxt;
            r_last  <= w_last_nxt;
            r_cout  <= w_cout_nxt;
            r_val   <= w_val_nxt;
            r_rdy   <= w_rdy_nxt;
        end
    end

    // Datapath storage carries no reset; it is always loaded before use.
    always_ff @(posedge i_clk) begin
        if (w_load) begin
            for (int i = 0; i < NUM_ELEMENTS; i++) begin
                r_coef[i] <= i_dat[i*DSP_BIT_LEN +: DSP_BIT_LEN];
            end
        end else if (w_adv) begin
            r_coef <= w_shift;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_carry_nxt = r_carry;
        w_idx_nxt   = r_idx;
        w_dat_nxt   = r_dat;
        w_last_nxt  = r_last;
        w_cout_nxt  = r_cout;
        w_val_nxt   = r_val;
        w_rdy_nxt   = r_rdy;
        w_load      = 1'b0;
        w_adv       = 1'b0;
        w_idx_inc   = r_idx + IDX_W'(1);

        case (r_state)
            IDLE: begin
                w_rdy_nxt = 1'b1;
                w_val_nxt = 1'b0;
                if (i_val && r_rdy) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                    w_rdy_nxt   = 1'b0;
                    w_val_nxt   = 1'b1;
                    w_carry_nxt = '0;
                    w_idx_nxt   = '0;
                    w_dat_nxt   = w_in0[WORD_LEN-1:0];
                    w_last_nxt  = (LAST_IDX == 0);
                    w_cout_nxt  = (LAST_IDX == 0) ? 2'(w_in0 >> WORD_LEN) : 2'b00;
                end
            end
            RUN: begin
                if (r_val && i_rdy) begin
                    if (r_last) begin
                        w_state_nxt = IDLE;
                        w_val_nxt   = 1'b0;
                        w_rdy_nxt   = 1'b1;
                        w_last_nxt  = 1'b0;
                        w_idx_nxt   = '0;
                        w_dat_nxt   = '0;
                        w_cout_nxt  = '0;
                        w_carry_nxt = '0;
                    end else begin
                        w_adv       = 1'b1;
                        w_carry_nxt = w_carry_adv;
                        w_idx_nxt   = w_idx_inc;
                        w_dat_nxt   = w_sum_nxt[WORD_LEN-1:0];
                        w_last_nxt  = (w_idx_inc == IDX_W'(LAST_IDX));
                        w_cout_nxt  = (w_idx_inc == IDX_W'(LAST_IDX)) ? 2'(w_sum_nxt >> WORD_LEN)
                                                                      : 2'b00;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_rdy   = r_rdy;
    assign o_val   = r_val;
    assign o_dat   = r_dat;
    assign o_idx   = r_idx;
    assign o_last  = r_last;
    assign o_carry = r_cout;

endmodule

// File: tb/tb_redun_to_canon_serializer.sv
// Randomized scoreboard bench for redun_to_canon_serializer; the reference model sums
// coefficients as one wide integer and slices the canonical words from it.
module tb_redun_to_canon_serializer;

    localparam int unsigned N     = 66;
    localparam int unsigned DW    = 17;
    localparam int unsigned WW    = 16;
    localparam int unsigned IW    = $clog2(N);
    localparam int unsigned BIG_W = WW*N + 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_val;
    logic              o_rdy;
    logic [N*DW-1:0]   i_dat;
    logic              o_val;
    logic              i_rdy;
    logic [WW-1:0]     o_dat;
    logic [IW-1:0]     o_idx;
    logic              o_last;
    logic [1:0]        o_carry;

    redun_to_canon_serializer #(
        .NUM_ELEMENTS(N),
        .DSP_BIT_LEN (DW),
        .WORD_LEN    (WW),
        .IDX_W       (IW)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_val  (i_val),
        .o_rdy  (o_rdy),
        .i_dat  (i_dat),
        .o_val  (o_val),
        .i_rdy  (i_rdy),
        .o_dat  (o_dat),
        .o_idx  (o_idx),
        .o_last (o_last),
        .o_carry(o_carry)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WW-1:0] dat;
        int unsigned   idx;
        logic          last;
        logic [1:0]    carry;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   rdy_mode = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic fail_event(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s actual=timeout required=event t=%0t", name, $time);
    endtask

    // Reference: value = sum coef[i] * 2^(16i); words and final carry are slices of it.
    task automatic push_model(input logic [N*DW-1:0] v);
        logic [BIG_W-1:0] acc;
        exp_t             e;
        acc = '0;
        for (int i = 0; i < N; i++) begin
            acc = acc + (BIG_W'(v[i*DW +: DW]) << (WW*i));
        end
        for (int i = 0; i < N; i++) begin
            e.dat   = acc[i*WW +: WW];
            e.idx   = i;
            e.last  = (i == N-1);
            e.carry = (i == N-1) ? acc[BIG_W-1 -: 2] : 2'b00;
            exp_q.push_back(e);
        end
    endtask

    function automatic logic [N*DW-1:0] rand_vec(input int kind);
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) begin
            case (kind)
                1:       v[i*DW +: DW] = '1;
                2:       v[i*DW +: DW] = 17'h1FF00 | DW'($urandom_range(0, 255));
                default: v[i*DW +: DW] = DW'($urandom);
            endcase
        end
        return v;
    endfunction

    // Monitor: pops on every accepted beat, checks hold-stability during stalls.
    logic [WW-1:0] s_dat;
    logic [IW-1:0] s_idx;
    logic          s_last;
    logic [1:0]    s_carry;
    bit            prev_stall = 0;
    bit            last_acc   = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n !== 1'b1) begin
            prev_stall = 0;
            last_acc   = 0;
        end else begin
            if (last_acc) begin
                chk("rdy_after_last", 64'(o_rdy), 64'(1));
                chk("val_after_last", 64'(o_val), 64'(0));
                last_acc = 0;
            end
            if (!o_val) begin
                chk("idle_idx_carry_last", 64'({o_idx, o_carry, o_last}), 64'(0));
            end else begin
                if (prev_stall) begin
                    chk("stall_hold", 64'({o_dat, o_idx, o_last, o_carry}),
                        64'({s_dat, s_idx, s_last, s_carry}));
                end
                if (i_rdy) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_word actual=idx%0d required=none t=%0t", o_idx, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("word_dat", 64'(o_dat), 64'(e.dat));
                        chk("word_idx", 64'(o_idx), 64'(e.idx));
                        chk("word_last", 64'(o_last), 64'(e.last));
                        if (e.last) chk("final_carry", 64'(o_carry), 64'(e.carry));
                        if (o_last) last_acc = 1;
                    end
                end
            end
            prev_stall = o_val && !i_rdy;
            s_dat   = o_dat;
            s_idx   = o_idx;
            s_last  = o_last;
            s_carry = o_carry;
        end
    end

    // Downstream ready: always-on, or random with forced 3-cycle stalls at idx 0 and idx N-1.
    initial begin
        int           hold_cnt;
        logic [IW-1:0] seen_idx;
        hold_cnt = 0;
        seen_idx = '1;
        i_rdy    = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!o_val || o_idx != seen_idx) hold_cnt = 0;
            seen_idx = o_idx;
            if (rdy_mode == 0) begin
                i_rdy = 1'b1;
            end else if (o_val && (o_idx == 0 || o_idx == IW'(N-1)) && hold_cnt < 3) begin
                i_rdy = 1'b0;
                hold_cnt++;
            end else begin
                i_rdy = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic send(input logic [N*DW-1:0] v);
        int t;
        t = 0;
        @(posedge clk);
        #1;
        i_dat = v;
        i_val = 1'b1;
        forever begin
            @(negedge clk);
            if (o_rdy) break;
            t++;
            if (t > 2000) begin
                fail_event("capture_wait");
                i_val = 1'b0;
                return;
            end
        end
        push_model(v);
        @(posedge clk);
        #1;
        i_val = 1'b0;
        i_dat = rand_vec(0);
    endtask

    // i_val held high: each next capture must follow the previous one by exactly N+1 cycles.
    task automatic send_continuous(input int k);
        int t;
        int cnt;
        @(posedge clk);
        #1;
        i_val = 1'b1;
        i_dat = rand_vec(0);
        t = 0;
        forever begin
            @(negedge clk);
            if (o_rdy) break;
            t++;
            if (t > 2000) begin
                fail_event("cont_first_capture");
                i_val = 1'b0;
                return;
            end
        end
        push_model(i_dat);
        for (int v = 1; v < k; v++) begin
            cnt = 0;
            forever begin
                @(posedge clk);
                #1;
                i_dat = rand_vec(0);
                @(negedge clk);
                cnt++;
                if (o_rdy || cnt > 2000) break;
            end
            chk("cont_spacing", 64'(cnt), 64'(N+1));
            push_model(i_dat);
        end
        @(posedge clk);
        #1;
        i_val = 1'b0;
    endtask

    initial begin
        logic [N*DW-1:0] v;
        int              t;

        // Reset held with i_val asserted: nothing may be captured.
        rst_n = 1'b0;
        i_val = 1'b1;
        i_dat = rand_vec(1);
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("rst_val", 64'(o_val), 64'(0));
            chk("rst_rdy", 64'(o_rdy), 64'(0));
        end
        chk("rst_outputs", 64'({o_dat, o_idx, o_last, o_carry}), 64'(0));
        i_val = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rdy_after_rst", 64'(o_rdy), 64'(1));
        chk("val_after_rst", 64'(o_val), 64'(0));

        // Directed vectors with continuous ready.
        rdy_mode = 0;
        send(rand_vec(1));
        v = '0;
        v[DW-1:0] = 17'h10000;
        send(v);
        send('0);

        // Random vectors under random backpressure.
        rdy_mode = 1;
        repeat (10) send(rand_vec(int'($urandom_range(0, 2))));

        rdy_mode = 0;
        send_continuous(3);

        // Reset for one cycle while the word at idx 10 is presented.
        send(rand_vec(1));
        t = 0;
        forever begin
            @(posedge clk);
            #1;
            if (o_val && o_idx == IW'(10)) break;
            t++;
            if (t > 2000) begin
                fail_event("reach_idx10");
                break;
            end
        end
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst_val", 64'(o_val), 64'(0));
        chk("midrst_rdy", 64'(o_rdy), 64'(0));
        chk("midrst_outputs", 64'({o_dat, o_idx, o_last, o_carry}), 64'(0));
        @(posedge clk);
        #1;
        chk("midrst_rdy_rise", 64'(o_rdy), 64'(1));
        send('0);
        rdy_mode = 1;
        send(rand_vec(2));

        t = 0;
        while ((exp_q.size() != 0 || o_val) && t < 3000) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain_queue_empty", 64'(exp_q.size()), 64'(0));
        chk("drain_val_low", 64'(o_val), 64'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
